// File: rtl/spectrum_peak_tracker.sv
// Streaming spectrum peak tracker: finds the largest and second-largest bins
// above a per-frame threshold, reporting both with a one-cycle done pulse.
module spectrum_peak_tracker #(
  parameter int DATA_W    = 32,
  parameter int INDEX_W   = 9,
  parameter int FRAME_LEN = 512,
  parameter int MIN_BIN   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               data_valid,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [DATA_W-1:0]  threshold,
  output logic               busy,
  output logic               done,
  output logic [INDEX_W-1:0] peak_index,
  output logic [DATA_W-1:0]  peak_value,
  output logic               peak_found,
  output logic [INDEX_W-1:0] second_index,
  output logic [DATA_W-1:0]  second_value,
  output logic               second_found
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  localparam logic [INDEX_W-1:0] LAST_BIN = INDEX_W'(FRAME_LEN - 1);
  localparam logic [INDEX_W:0]   MIN_B    = (INDEX_W + 1)'(MIN_BIN);

  state_t              state, state_nxt;
  logic [INDEX_W-1:0]  bin;
  logic [DATA_W-1:0]   thr;

  logic [INDEX_W-1:0]  best_idx, sec_idx;
  logic [DATA_W-1:0]   best_val, sec_val;
  logic                best_fnd, sec_fnd;

  logic                accept, qualify, last;
  logic [INDEX_W-1:0]  cur_bin;
  logic [DATA_W-1:0]   cur_thr;
  logic [INDEX_W-1:0]  nb_idx, ns_idx;
  logic [DATA_W-1:0]   nb_val, ns_val;
  logic                nb_fnd, ns_fnd;

  // A start cycle evaluates its own sample (bin 0) against freshly cleared
  // candidates and the incoming threshold, so both are muxed in here.
  always_comb begin
    accept  = start || (state == SCAN && data_valid);
    cur_bin = start ? '0 : bin;
    cur_thr = start ? threshold : thr;
    nb_idx  = start ? '0 : best_idx;
    nb_val  = start ? '0 : best_val;
    nb_fnd  = start ? 1'b0 : best_fnd;
    ns_idx  = start ? '0 : sec_idx;
    ns_val  = start ? '0 : sec_val;
    ns_fnd  = start ? 1'b0 : sec_fnd;
    qualify = accept && ({1'b0, cur_bin} >= MIN_B) && (data_in > cur_thr);
    last    = accept && (cur_bin == LAST_BIN);
    if (qualify) begin
      if (!nb_fnd || data_in > nb_val) begin
        ns_idx = nb_idx;
        ns_val = nb_val;
        ns_fnd = nb_fnd;
        nb_idx = cur_bin;
        nb_val = data_in;
        nb_fnd = 1'b1;
      end else if (!ns_fnd || data_in > ns_val) begin
        ns_idx = cur_bin;
        ns_val = data_in;
        ns_fnd = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (start) state_nxt = SCAN;
               else if (last) state_nxt = REPORT;
      REPORT:  state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bin          <= '0;
      thr          <= '0;
      best_idx     <= '0;
      best_val     <= '0;
      best_fnd     <= 1'b0;
      sec_idx      <= '0;
      sec_val      <= '0;
      sec_fnd      <= 1'b0;
      peak_index   <= '0;
      peak_value   <= '0;
      peak_found   <= 1'b0;
      second_index <= '0;
      second_value <= '0;
      second_found <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) thr <= threshold;
      if (accept) begin
        best_idx <= nb_idx;
        best_val <= nb_val;
        best_fnd <= nb_fnd;
        sec_idx  <= ns_idx;
        sec_val  <= ns_val;
        sec_fnd  <= ns_fnd;
        // Counter parks on the last bin instead of wrapping.
        bin      <= last ? cur_bin : cur_bin + INDEX_W'(1);
      end
      // Results are loaded on the edge entering REPORT so they are valid with done.
      if (state == SCAN && !start && last) begin
        peak_index   <= nb_idx;
        peak_value   <= nb_val;
        peak_found   <= nb_fnd;
        second_index <= ns_idx;
        second_value <= ns_val;
        second_found <= ns_fnd;
      end
    end
  end

  assign busy = (state == SCAN);
  assign done = (state == REPORT);

endmodule

// File: tb/tb_spectrum_peak_tracker.sv
// Directed bench for spectrum_peak_tracker: table of whole frames plus
// hand-written abort and mid-frame reset sequences.
module tb_spectrum_peak_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        data_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] threshold = '0;
  logic        busy, done;
  logic [2:0]  peak_index, second_index;
  logic [15:0] peak_value, second_value;
  logic        peak_found, second_found;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    string             name;
    logic [15:0]       thr;
    logic [7:0][15:0]  s;
    logic              stall;
    logic [2:0]        pi;
    logic [15:0]       pv;
    logic              pf;
    logic [2:0]        si;
    logic [15:0]       sv;
    logic              sf;
  } vec_t;

  spectrum_peak_tracker #(
    .DATA_W(16), .INDEX_W(3), .FRAME_LEN(8), .MIN_BIN(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .data_valid(data_valid),
    .data_in(data_in), .threshold(threshold), .busy(busy), .done(done),
    .peak_index(peak_index), .peak_value(peak_value), .peak_found(peak_found),
    .second_index(second_index), .second_value(second_value),
    .second_found(second_found)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] pi, input logic [15:0] pv,
                         input logic pf, input logic [2:0] si, input logic [15:0] sv,
                         input logic sf);
    chk({tag, ".peak_index"},   32'(peak_index),   32'(pi));
    chk({tag, ".peak_value"},   32'(peak_value),   32'(pv));
    chk({tag, ".peak_found"},   32'(peak_found),   32'(pf));
    chk({tag, ".second_index"}, 32'(second_index), 32'(si));
    chk({tag, ".second_value"}, 32'(second_value), 32'(sv));
    chk({tag, ".second_found"}, 32'(second_found), 32'(sf));
  endtask

  function automatic vec_t mk(input string n, input logic [15:0] thr, input logic stall,
                              input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3,
                              input logic [15:0] a4, input logic [15:0] a5,
                              input logic [15:0] a6, input logic [15:0] a7,
                              input logic [2:0] pi, input logic [15:0] pv, input logic pf,
                              input logic [2:0] si, input logic [15:0] sv, input logic sf);
    vec_t v;
    v.name = n; v.thr = thr; v.stall = stall;
    v.s[0] = a0; v.s[1] = a1; v.s[2] = a2; v.s[3] = a3;
    v.s[4] = a4; v.s[5] = a5; v.s[6] = a6; v.s[7] = a7;
    v.pi = pi; v.pv = pv; v.pf = pf; v.si = si; v.sv = sv; v.sf = sf;
    return v;
  endfunction

  task automatic run_frame(input vec_t v);
    int early;
    early = 0;
    @(negedge clk);
    threshold = v.thr; start = 1'b1; data_valid = 1'b1; data_in = v.s[0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) chk({v.name, ".busy_after_start"}, 32'(busy), 32'd1);
      if (done) early++;
      if (v.stall) begin
        repeat (2) begin
          data_valid = 1'b0; data_in = 16'hFFFF;
          @(negedge clk);
          if (done || !busy) early++;
        end
      end
      data_valid = 1'b1; data_in = v.s[i];
    end
    @(negedge clk);
    data_valid = 1'b0; data_in = '0;
    chk({v.name, ".early_done_or_idle"}, 32'(early), 32'd0);
    chk({v.name, ".done"}, 32'(done), 32'd1);
    chk({v.name, ".busy_in_report"}, 32'(busy), 32'd0);
    chk_out(v.name, v.pi, v.pv, v.pf, v.si, v.sv, v.sf);
    @(negedge clk);
    chk({v.name, ".done_one_cycle"}, 32'(done), 32'd0);
  endtask

  vec_t vecs[7];
  vec_t held;
  int   bad;

  initial begin
    vecs[0] = mk("tie_order", 16'd0, 1'b0, 9, 3, 7, 2, 7, 1, 5, 4,  3'd2, 16'd7, 1'b1, 3'd4, 16'd7, 1'b1);
    vecs[1] = mk("thr6_ramp", 16'd6, 1'b0, 0, 1, 2, 3, 4, 5, 6, 7,  3'd7, 16'd7, 1'b1, 3'd0, 16'd0, 1'b0);
    vecs[2] = mk("stalled",   16'd0, 1'b1, 9, 3, 7, 2, 7, 1, 5, 4,  3'd2, 16'd7, 1'b1, 3'd4, 16'd7, 1'b1);
    vecs[3] = mk("below_thr", 16'd100, 1'b0, 50, 50, 50, 50, 50, 50, 50, 50, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    vecs[4] = mk("best_shift", 16'd0, 1'b0, 0, 8, 6, 8, 3, 2, 1, 9, 3'd7, 16'd9, 1'b1, 3'd1, 16'd8, 1'b1);
    vecs[5] = mk("dc_only",   16'd0, 1'b0, 20, 0, 0, 0, 0, 0, 0, 0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    vecs[6] = mk("thr_equal", 16'd5, 1'b0, 5, 5, 6, 5, 5, 5, 5, 5,  3'd2, 16'd6, 1'b1, 3'd0, 16'd0, 1'b0);

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk_out("reset", 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    reset = 1'b0;

    foreach (vecs[k]) run_frame(vecs[k]);
    held = vecs[6];

    // Abort: four samples, then a fresh start; only the second frame reports.
    @(negedge clk);
    #1 done_cnt = 0;
    threshold = 16'd0; start = 1'b1; data_valid = 1'b1; data_in = 16'd1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0; data_in = 16'(i + 1);
    end
    @(negedge clk);
    start = 1'b1; data_in = 16'd0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0; data_in = 16'(i);
    end
    #1;
    chk("abort.no_done_yet", 32'(done_cnt), 32'd0);
    chk_out("abort.held", held.pi, held.pv, held.pf, held.si, held.sv, held.sf);
    @(negedge clk);
    data_valid = 1'b0;
    chk("abort.done", 32'(done), 32'd1);
    chk_out("abort.new", 3'd7, 16'd7, 1'b1, 3'd6, 16'd6, 1'b1);
    @(negedge clk);
    #1;
    chk("abort.single_done", 32'(done_cnt), 32'd1);

    // Reset mid-scan at bin 5, asserted between clock edges.
    @(negedge clk);
    threshold = 16'd0; start = 1'b1; data_valid = 1'b1; data_in = 16'd10;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0; data_in = 16'(20 + i);
    end
    @(negedge clk);
    chk("rst_mid.busy_before", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.done", 32'(done), 32'd0);
    chk_out("rst_mid", 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 done_cnt = 0;
    bad = 0;
    data_valid = 1'b1; data_in = 16'd99;
    repeat (12) begin
      @(negedge clk);
      if (busy) bad++;
    end
    data_valid = 1'b0;
    #1;
    chk("post_rst.busy_never", 32'(bad), 32'd0);
    chk("post_rst.no_done", 32'(done_cnt), 32'd0);
    chk("post_rst.peak_found", 32'(peak_found), 32'd0);

    run_frame(vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
